// File: rtl/floo_axis_credit_arbiter.sv
// -----------------------------------------------------------------------------
// floo_axis_credit_arbiter
//
// Merges the NoC req and rsp flit channels onto one AXIS serial-link stream.
// Each channel owns a credit counter that mirrors the free slots of its remote
// receive buffer, so a stalled channel cannot consume the other channel's
// buffer space. Ties between eligible channels alternate via a priority pointer.
//
// Handshake semantics (all ports): a transfer happens on a rising clk_i edge
// where valid and ready are both 1. A valid, once raised, holds with stable
// data until that transfer. The readies here are combinational grants.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i/_ready_o/_data_i   req flit input channel
//   rsp_valid_i/_ready_o/_data_i   rsp flit input channel
//   crd_ret_req_i/_rsp_i   one-cycle credit-return pulses from the remote side
//   axis_tvalid_o/_tready_i/_tdata_o  AXIS out, tdata = {hdr, flit}, hdr=1 req
//   crd_req_o, crd_rsp_o   current credit counts
//   crd_err_o              sticky: credit returned while counter was full
// -----------------------------------------------------------------------------
module floo_axis_credit_arbiter #(
  parameter int unsigned FlitWidth  = 64,
  parameter int unsigned NumCredits = 8,
  // Derived; sizes the credit counters. Leave at its default.
  parameter int unsigned CrdWidth   = $clog2(NumCredits + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [FlitWidth-1:0] req_data_i,
  input  logic                 rsp_valid_i,
  output logic                 rsp_ready_o,
  input  logic [FlitWidth-1:0] rsp_data_i,
  input  logic                 crd_ret_req_i,
  input  logic                 crd_ret_rsp_i,
  output logic                 axis_tvalid_o,
  input  logic                 axis_tready_i,
  output logic [FlitWidth:0]   axis_tdata_o,
  output logic [CrdWidth-1:0]  crd_req_o,
  output logic [CrdWidth-1:0]  crd_rsp_o,
  output logic                 crd_err_o
);

  localparam logic [CrdWidth-1:0] CrdMax = CrdWidth'(NumCredits);
  localparam logic [CrdWidth-1:0] CrdOne = CrdWidth'(1);

  logic                tvalid_q, tvalid_d;
  logic [FlitWidth:0]  tdata_q, tdata_d;
  logic                prio_req_q, prio_req_d;  // 1: req wins a tie
  logic [CrdWidth-1:0] crd_req_q, crd_req_d;
  logic [CrdWidth-1:0] crd_rsp_q, crd_rsp_d;
  logic                err_q, err_d;

  logic load_en;
  logic elig_req, elig_rsp;
  logic gnt_req, gnt_rsp;
  logic req_fire, rsp_fire;

  // Arbitration. Eligibility uses the registered counters only, so a credit
  // returned at count 0 makes the channel eligible one cycle later.
  always_comb begin
    load_en  = !tvalid_q || axis_tready_i;
    elig_req = req_valid_i && (crd_req_q != '0);
    elig_rsp = rsp_valid_i && (crd_rsp_q != '0);
    gnt_req  = elig_req && (!elig_rsp || prio_req_q);
    gnt_rsp  = elig_rsp && (!elig_req || !prio_req_q);
    // Readies are forced low during reset even though the counters read full.
    req_fire = rst_ni && load_en && gnt_req;
    rsp_fire = rst_ni && load_en && gnt_rsp;
  end

  // Output register and priority pointer.
  always_comb begin
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    prio_req_d = prio_req_q;
    if (load_en) begin
      if (req_fire) begin
        tvalid_d   = 1'b1;
        tdata_d    = {1'b1, req_data_i};
        prio_req_d = 1'b0;
      end else if (rsp_fire) begin
        tvalid_d   = 1'b1;
        tdata_d    = {1'b0, rsp_data_i};
        prio_req_d = 1'b1;
      end else begin
        // Drained with nothing to replace it; tdata keeps its last value.
        tvalid_d = 1'b0;
      end
    end
  end

  // Credit counters. A grant and a return in the same cycle cancel out.
  always_comb begin
    crd_req_d = crd_req_q;
    crd_rsp_d = crd_rsp_q;
    err_d     = err_q;
    case ({req_fire, crd_ret_req_i})
      2'b10:   crd_req_d = crd_req_q - CrdOne;
      2'b01: begin
        if (crd_req_q == CrdMax) err_d = 1'b1;
        else                     crd_req_d = crd_req_q + CrdOne;
      end
      default: ;
    endcase
    case ({rsp_fire, crd_ret_rsp_i})
      2'b10:   crd_rsp_d = crd_rsp_q - CrdOne;
      2'b01: begin
        if (crd_rsp_q == CrdMax) err_d = 1'b1;
        else                     crd_rsp_d = crd_rsp_q + CrdOne;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      prio_req_q <= 1'b1;
      crd_req_q  <= CrdMax;
      crd_rsp_q  <= CrdMax;
      err_q      <= 1'b0;
    end else begin
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      prio_req_q <= prio_req_d;
      crd_req_q  <= crd_req_d;
      crd_rsp_q  <= crd_rsp_d;
      err_q      <= err_d;
    end
  end

  assign req_ready_o   = req_fire;
  assign rsp_ready_o   = rsp_fire;
  assign axis_tvalid_o = tvalid_q;
  assign axis_tdata_o  = tdata_q;
  assign crd_req_o     = crd_req_q;
  assign crd_rsp_o     = crd_rsp_q;
  assign crd_err_o     = err_q;

endmodule
